// File: rtl/saladin_mem_pkg.sv
// Shared widths and defaults for the dual-port memory and its port masters.
package saladin_mem_pkg;

   localparam int DATA_W        = 72;
   localparam int ADDR_W        = 10;
   localparam int RSP_DEPTH_DEF = 4;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;

   // Width of an occupancy counter able to hold 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/mem_port_master_if.sv
// Request, response and memory-port signals of one memory port master.
//
// Handshake rules: a transfer happens on a rising clk edge where valid and
// ready are both high. A producer holding valid keeps its payload stable until
// the transfer; ready never depends on valid in this block. Responses leave in
// the order their reads were accepted.
interface mem_port_master_if
   import saladin_mem_pkg::*;
#(
   parameter int DATA = DATA_W,
   parameter int ADDR = ADDR_W
);

   logic            req_valid;
   logic            req_ready;
   logic            req_wr;
   logic [ADDR-1:0] req_addr;
   logic [DATA-1:0] req_wdata;

   logic            rsp_valid;
   logic            rsp_ready;
   logic [DATA-1:0] rsp_data;

   logic            mem_wr;
   logic [ADDR-1:0] mem_addr;
   logic [DATA-1:0] mem_din;
   logic [DATA-1:0] mem_dout;

   // Port master side.
   modport master (
      input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, mem_dout,
      output req_ready, rsp_valid, rsp_data, mem_wr, mem_addr, mem_din
   );

   // Requester / consumer / memory side.
   modport slave (
      output req_valid, req_wr, req_addr, req_wdata, rsp_ready, mem_dout,
      input  req_ready, rsp_valid, rsp_data, mem_wr, mem_addr, mem_din
   );

endinterface

// File: rtl/mem_port_master_sync_fifo.sv
// Small synchronous FIFO with combinational head read from registered storage.
// A push and a pop in the same cycle are both honoured even when full.
module sync_fifo #(
   parameter int WIDTH = 72,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop_ok;

   // A pop on an empty FIFO is ignored so the pointers cannot drift.
   assign pop_ok = pop && (count != '0);
   assign dout   = storage[rd_ptr];

   // Data storage: written on push, not reset.
   always_ff @(posedge clk) begin
      if (push) begin
         storage[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_port_master.sv
// Turns a valid/ready request stream into memory-port cycles and returns read
// data through a credit-protected response FIFO, so backpressure on the
// response side never drops a word.
module mem_port_master
   import saladin_mem_pkg::*;
#(
   parameter int DATA      = DATA_W,
   parameter int ADDR      = ADDR_W,
   parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_master_if.master bus
);

   localparam int CW = cnt_w(RSP_DEPTH);

   logic            rd_pend;
   logic [CW-1:0]   count;
   logic [CW:0]     occupancy;
   logic            acc;
   logic            pop;
   logic [ADDR-1:0] last_addr;
   logic [DATA-1:0] last_din;

   // Credit counts buffered words plus the read whose data is on mem_dout now,
   // so a full buffer stalls every request, writes included.
   assign occupancy     = {1'b0, count} + {{CW{1'b0}}, rd_pend};
   assign bus.req_ready = !rst && (occupancy < (CW+1)'(RSP_DEPTH));
   assign acc           = bus.req_valid && bus.req_ready;

   // Zero-latency issue; idle cycles replay the last address, which is a
   // harmless read since rd_pend stays low.
   assign bus.mem_wr   = acc && bus.req_wr;
   assign bus.mem_addr = acc ? bus.req_addr  : last_addr;
   assign bus.mem_din  = acc ? bus.req_wdata : last_din;

   assign bus.rsp_valid = (count != '0);
   assign pop           = bus.rsp_valid && bus.rsp_ready;

   // Remember the read whose registered data arrives next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend <= 1'b0;
      end else begin
         rd_pend <= acc && !bus.req_wr;
      end
   end

   // Hold the last issued address/data for idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_addr <= '0;
         last_din  <= '0;
      end else if (acc) begin
         last_addr <= bus.req_addr;
         last_din  <= bus.req_wdata;
      end
   end

   sync_fifo #(
      .WIDTH (DATA),
      .DEPTH (RSP_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rd_pend),
      .din   (bus.mem_dout),
      .pop   (pop),
      .dout  (bus.rsp_data),
      .count (count)
   );

endmodule

// File: tb/tb_mem_port_master.sv
// Directed bench for mem_port_master attached to a write-first memory model.
module tb_mem_port_master
   import saladin_mem_pkg::*;
;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] mem_arr [1024];

   mem_port_master_if #(.DATA(DATA_W), .ADDR(ADDR_W)) bus ();

   mem_port_master #(
      .DATA      (DATA_W),
      .ADDR      (ADDR_W),
      .RSP_DEPTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // Write-first memory port with registered read data.
   always @(posedge clk) begin
      if (bus.mem_wr) begin
         mem_arr[bus.mem_addr] <= bus.mem_din;
      end
      bus.mem_dout <= bus.mem_wr ? bus.mem_din : mem_arr[bus.mem_addr];
   end

   // Buffer occupancy must never exceed its depth.
   always @(negedge clk) begin
      if (!rst && dut.u_fifo.count > 3'd4) begin
         errors++;
         $display("FAIL overflow: count=%0d limit=4", dut.u_fifo.count);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_req();
      bus.req_valid = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int n;
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b1;
      bus.req_addr  = a;
      bus.req_wdata = d;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         cyc();
         n++;
      end
      checks++;
      if (n == 20) begin
         errors++;
         $display("FAIL write_accept: addr=%0d never accepted within 20 cycles", a);
      end
      cyc();
      bus.req_valid = 1'b0;
      bus.req_wr    = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      idle_req();
      bus.rsp_ready = 1'b0;
      cyc();
      cyc();
      checks++;
      if (bus.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_req_ready: got %b want 0", bus.req_ready);
      end
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_ready: got %b want 1", bus.req_ready);
      end
   endtask

   task automatic test_write_read();
      bus.rsp_ready = 1'b0;
      do_write(10'd5, 72'hAB);
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b0;
      bus.req_addr  = 10'd5;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL wr_rd_ready: got %b want 1", bus.req_ready);
      end
      cyc();
      bus.req_valid = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL wr_rd_early: rsp_valid got %b want 0 one cycle after accept", bus.rsp_valid);
      end
      cyc();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 72'hAB) begin
         errors++;
         $display("FAIL wr_rd_rsp: valid=%b data=%h want valid=1 data=ab", bus.rsp_valid, bus.rsp_data);
      end
      bus.rsp_ready = 1'b1;
      cyc();
      bus.rsp_ready = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL wr_rd_drain: rsp_valid got %b want 0", bus.rsp_valid);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         do_write(10'(i), 72'h100 + 72'(i));
      end
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k < 8) begin
            bus.req_valid = 1'b1;
            bus.req_wr    = 1'b0;
            bus.req_addr  = 10'(k);
            checks++;
            if (bus.req_ready !== 1'b1) begin
               errors++;
               $display("FAIL b2b_ready: k=%0d got %b want 1", k, bus.req_ready);
            end
         end else begin
            bus.req_valid = 1'b0;
         end
         cyc();
         if (k >= 1 && k <= 8) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 72'h100 + 72'(k-1)) begin
               errors++;
               $display("FAIL b2b_rsp: k=%0d valid=%b data=%h want valid=1 data=%h",
                        k, bus.rsp_valid, bus.rsp_data, 72'h100 + 72'(k-1));
            end
         end
         if (k == 9) begin
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
               errors++;
               $display("FAIL b2b_empty: rsp_valid got %b want 0", bus.rsp_valid);
            end
         end
      end
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int acc_cnt;
      int nxt;
      int got;
      logic [DATA_W-1:0] exp;
      exp_q.delete();
      acc_cnt = 0;
      nxt     = 0;
      got     = 0;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b0;
      for (int c = 0; c < 8; c++) begin
         bus.req_addr = 10'(nxt);
         if (bus.req_ready) begin
            exp_q.push_back(72'h100 + 72'(nxt));
            acc_cnt++;
            nxt = (nxt + 1) % 8;
         end
         cyc();
      end
      checks++;
      if (acc_cnt != 4 || bus.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_stall: accepted=%0d ready=%b want accepted=4 ready=0", acc_cnt, bus.req_ready);
      end
      bus.rsp_ready = 1'b1;
      for (int c = 0; c < 40 && got < 8; c++) begin
         bus.req_valid = (acc_cnt < 8);
         bus.req_addr  = 10'(nxt);
         if (bus.req_valid && bus.req_ready) begin
            exp_q.push_back(72'h100 + 72'(nxt));
            acc_cnt++;
            nxt = (nxt + 1) % 8;
         end
         if (bus.rsp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL bp_extra: unexpected data=%h", bus.rsp_data);
            end else begin
               exp = exp_q.pop_front();
               if (bus.rsp_data !== exp) begin
                  errors++;
                  $display("FAIL bp_order: got %h want %h", bus.rsp_data, exp);
               end
            end
            got++;
         end
         cyc();
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      checks++;
      if (got != 8 || acc_cnt != 8 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_total: responses=%0d accepted=%0d left=%0d want 8 8 0",
                  got, acc_cnt, exp_q.size());
      end
   endtask

   task automatic test_write_then_read();
      bus.rsp_ready = 1'b0;
      do_write(10'd9, 72'h33);
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_only_rsp: cycle=%0d rsp_valid got %b want 0", c, bus.rsp_valid);
         end
         cyc();
      end
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b1;
      bus.req_addr  = 10'd9;
      bus.req_wdata = 72'h55;
      cyc();
      bus.req_wr    = 1'b0;
      cyc();
      bus.req_valid = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL raw_early: rsp_valid got %b want 0", bus.rsp_valid);
      end
      cyc();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 72'h55) begin
         errors++;
         $display("FAIL raw_rsp: valid=%b data=%h want valid=1 data=55", bus.rsp_valid, bus.rsp_data);
      end
      bus.rsp_ready = 1'b1;
      cyc();
      bus.rsp_ready = 1'b0;
   endtask

   // With the credit rule a buffer at 4 cannot also have a pending push, so
   // the simultaneous push/pop is taken at the fullest reachable point:
   // 3 buffered + 1 landing while the head is popped.
   task automatic test_full_pop();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.req_addr = 10'(i);
         checks++;
         if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_fill_ready: i=%0d got %b want 1", i, bus.req_ready);
         end
         cyc();
      end
      bus.req_valid = 1'b0;
      checks++;
      if (dut.u_fifo.count !== 3'd3 || bus.req_ready !== 1'b0 || bus.rsp_data !== 72'h100) begin
         errors++;
         $display("FAIL full_pre: count=%0d ready=%b data=%h want 3 0 100",
                  dut.u_fifo.count, bus.req_ready, bus.rsp_data);
      end
      bus.rsp_ready = 1'b1;
      cyc();
      checks++;
      if (dut.u_fifo.count !== 3'd3 || bus.rsp_data !== 72'h101) begin
         errors++;
         $display("FAIL full_pushpop: count=%0d data=%h want 3 101", dut.u_fifo.count, bus.rsp_data);
      end
      for (int j = 2; j < 4; j++) begin
         cyc();
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 72'h100 + 72'(j)) begin
            errors++;
            $display("FAIL full_order: j=%0d valid=%b data=%h want 1 %h",
                     j, bus.rsp_valid, bus.rsp_data, 72'h100 + 72'(j));
         end
      end
      cyc();
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_drain: rsp_valid got %b want 0", bus.rsp_valid);
      end
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.req_addr = 10'(i);
         cyc();
      end
      bus.req_valid = 1'b0;
      checks++;
      if (dut.u_fifo.count !== 3'd2 || dut.rd_pend !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre: count=%0d rd_pend=%b want 2 1", dut.u_fifo.count, dut.rd_pend);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst_ready: got %b want 0", bus.req_ready);
      end
      cyc();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale: cycle=%0d rsp_valid got %b want 0", c, bus.rsp_valid);
         end
         cyc();
      end
      bus.req_valid = 1'b1;
      bus.req_addr  = 10'd6;
      cyc();
      bus.req_valid = 1'b0;
      cyc();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 72'h106) begin
         errors++;
         $display("FAIL mid_read: valid=%b data=%h want 1 106", bus.rsp_valid, bus.rsp_data);
      end
      bus.rsp_ready = 1'b1;
      cyc();
      bus.rsp_ready = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_backpressure();
      test_write_then_read();
      test_full_pop();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
